// File: rtl/alu_seq_pkg.sv
// Shared opcodes, flag payload and sizing helper for the sequential ALU.
package alu_seq_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b011;
  localparam logic [2:0] OP_SUB  = 3'b100;
  localparam logic [2:0] OP_SHL  = 3'b101;
  localparam logic [2:0] OP_SHR  = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

  typedef struct packed {
    logic c;
    logic z;
    logic n;
    logic v;
  } flags_t;

  // Number of low b bits used as the shift amount.
  function automatic int unsigned shamt_w(input int unsigned width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Operand/op beat in, result/flags out, with valid/ready on both sides.
interface alu_seq_if #(parameter int unsigned WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       sel;
  logic             acc_en;
  logic             acc_clr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             flag_c;
  logic             flag_z;
  logic             flag_n;
  logic             flag_v;
  logic [WIDTH-1:0] acc;

  modport master (
    output in_valid, a, b, sel, acc_en, acc_clr, out_ready,
    input  in_ready, out_valid, out, flag_c, flag_z, flag_n, flag_v, acc
  );

  modport slave (
    input  in_valid, a, b, sel, acc_en, acc_clr, out_ready,
    output in_ready, out_valid, out, flag_c, flag_z, flag_n, flag_v, acc
  );
endinterface

// File: rtl/alu_seq_core.sv
// Combinational ALU datapath: result plus carry/borrow and signed overflow.
module alu_seq_core
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       sel,
  output logic [WIDTH-1:0] result_c,
  output logic             carry_c,
  output logic             ovf_c
);

  localparam int unsigned SHAMT_W = shamt_w(WIDTH);

  logic [WIDTH:0]   sum_c;
  logic [WIDTH:0]   diff_c;
  logic [SHAMT_W-1:0] shamt_c;

  always_comb begin
    sum_c    = {1'b0, a} + {1'b0, b};
    diff_c   = {1'b0, a} - {1'b0, b};
    shamt_c  = b[SHAMT_W-1:0];
    result_c = b;
    carry_c  = 1'b0;
    ovf_c    = 1'b0;
    case (sel)
      OP_ADD: begin
        result_c = sum_c[WIDTH-1:0];
        carry_c  = sum_c[WIDTH];
        ovf_c    = (a[WIDTH-1] == b[WIDTH-1]) && (sum_c[WIDTH-1] != a[WIDTH-1]);
      end
      OP_OR:  result_c = a | b;
      OP_AND: result_c = a & b;
      OP_XOR: result_c = a ^ b;
      // Top bit of the extended difference is the unsigned borrow.
      OP_SUB: begin
        result_c = diff_c[WIDTH-1:0];
        carry_c  = diff_c[WIDTH];
        ovf_c    = (a[WIDTH-1] != b[WIDTH-1]) && (diff_c[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SHL:  result_c = a << shamt_c;
      OP_SHR:  result_c = a >> shamt_c;
      default: result_c = b;
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with accumulator mode and a single-entry output stage.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input logic     clk,
  input logic     rst,
  alu_seq_if.slave bus
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  flags_t           flags_q, flags_d;
  logic [WIDTH-1:0] a_eff_c;
  logic [WIDTH-1:0] result_c;
  logic             carry_c;
  logic             ovf_c;
  logic             ready_c;
  logic             accept_c;

  assign ready_c  = (state_q == ST_EMPTY) || bus.out_ready;
  assign accept_c = bus.in_valid && ready_c;
  // A same-cycle clear wins over the accumulator as the A operand.
  assign a_eff_c  = bus.acc_clr ? '0 : (bus.acc_en ? acc_q : bus.a);

  alu_seq_core #(.WIDTH(WIDTH)) u_core (
    .a        (a_eff_c),
    .b        (bus.b),
    .sel      (bus.sel),
    .result_c (result_c),
    .carry_c  (carry_c),
    .ovf_c    (ovf_c)
  );

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    flags_d = flags_q;
    acc_d   = acc_q;
    if (accept_c) begin
      state_d   = ST_FULL;
      out_d     = result_c;
      flags_d.c = carry_c;
      flags_d.z = (result_c == '0);
      flags_d.n = result_c[WIDTH-1];
      flags_d.v = ovf_c;
    end else if (bus.out_ready) begin
      state_d = ST_EMPTY;
    end
    if (accept_c && bus.acc_en) begin
      acc_d = result_c;
    end else if (bus.acc_clr) begin
      acc_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      out_q   <= '0;
      flags_q <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      flags_q <= flags_d;
      acc_q   <= acc_d;
    end
  end

  assign bus.in_ready  = ready_c;
  assign bus.out_valid = (state_q == ST_FULL);
  assign bus.out       = out_q;
  assign bus.flag_c    = flags_q.c;
  assign bus.flag_z    = flags_q.z;
  assign bus.flag_n    = flags_q.n;
  assign bus.flag_v    = flags_q.v;
  assign bus.acc       = acc_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq at WIDTH 8, 4 and 16 against an arithmetic reference.
module tb_alu_seq;

  typedef struct packed {
    logic [31:0] r;
    logic        c;
    logic        v;
    logic        z;
    logic        n;
  } mres_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  alu_seq_if #(.WIDTH(8))  bus8 ();
  alu_seq_if #(.WIDTH(4))  bus4 ();
  alu_seq_if #(.WIDTH(16)) bus16 ();

  alu_seq #(.WIDTH(8))  u_dut8  (.clk(clk), .rst(rst), .bus(bus8));
  alu_seq #(.WIDTH(4))  u_dut4  (.clk(clk), .rst(rst), .bus(bus4));
  alu_seq #(.WIDTH(16)) u_dut16 (.clk(clk), .rst(rst), .bus(bus16));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic longint to_s(input int w, input longint unsigned x);
    longint unsigned full;
    full = 64'd1 << w;
    return (x >= full / 2) ? longint'(x) - longint'(full) : longint'(x);
  endfunction

  // Reference: ordinary integer arithmetic, then reduced modulo 2^w.
  function automatic mres_t ref_op(input int w, input int op,
                                   input longint unsigned a, input longint unsigned b);
    longint unsigned full;
    longint unsigned r;
    longint          sr;
    int              amt;
    mres_t           m;
    full = 64'd1 << w;
    amt  = int'(b % 64'(w));
    m    = '0;
    sr   = 0;
    case (op)
      0: r = a + b;
      1: r = a | b;
      2: r = a & b;
      3: r = a ^ b;
      4: r = a - b;
      5: r = a << amt;
      6: r = a >> amt;
      default: r = b;
    endcase
    if (op == 0) begin
      m.c = (r >= full);
      sr  = to_s(w, a) + to_s(w, b);
    end
    if (op == 4) begin
      m.c = (a < b);
      sr  = to_s(w, a) - to_s(w, b);
    end
    if (op == 0 || op == 4) m.v = (sr >= longint'(full / 2)) || (sr < -longint'(full / 2));
    r   = r % full;
    m.r = 32'(r);
    m.z = (r == 0);
    m.n = (r >= full / 2);
    return m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle8();
    bus8.in_valid = 1'b0; bus8.a = '0; bus8.b = '0; bus8.sel = '0;
    bus8.acc_en = 1'b0; bus8.acc_clr = 1'b0;
  endtask

  task automatic beat8(input logic [2:0] s, input logic [7:0] a, input logic [7:0] b);
    bus8.in_valid = 1'b1; bus8.sel = s; bus8.a = a; bus8.b = b;
  endtask

  task automatic test_reset();
    logic [12:0] got;
    rst = 1'b1;
    idle8();
    bus8.out_ready = 1'b1;
    beat8(3'b000, 8'h01, 8'h01);
    bus8.acc_en = 1'b1;
    bus4.in_valid = 1'b0; bus4.out_ready = 1'b1; bus4.acc_en = 1'b0; bus4.acc_clr = 1'b0;
    bus4.a = '0; bus4.b = '0; bus4.sel = '0;
    bus16.in_valid = 1'b0; bus16.out_ready = 1'b1; bus16.acc_en = 1'b0; bus16.acc_clr = 1'b0;
    bus16.a = '0; bus16.b = '0; bus16.sel = '0;
    tick();
    tick();
    rst = 1'b0;
    idle8();
    #1;
    got = {bus8.out_valid, bus8.out, bus8.flag_c, bus8.flag_z, bus8.flag_n, bus8.flag_v};
    checks++;
    if (got !== 13'h0) begin failures++; $display("FAIL reset_out got=%0h exp=0", got); end
    checks++;
    if (bus8.acc !== 8'h00) begin failures++; $display("FAIL reset_acc got=%0h exp=0", bus8.acc); end
    checks++;
    if (bus8.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", bus8.in_ready); end
  endtask

  task automatic test_flags();
    logic [12:0] got;
    bus8.out_ready = 1'b1;
    beat8(3'b000, 8'hF0, 8'h20);
    tick();
    got = {bus8.out_valid, bus8.out, bus8.flag_c, bus8.flag_z, bus8.flag_n, bus8.flag_v};
    checks++;
    if (got !== {1'b1, 8'h10, 4'b1000}) begin failures++; $display("FAIL add_carry got=%0h exp=%0h", got, {1'b1, 8'h10, 4'b1000}); end
    beat8(3'b100, 8'h05, 8'h07);
    tick();
    got = {bus8.out_valid, bus8.out, bus8.flag_c, bus8.flag_z, bus8.flag_n, bus8.flag_v};
    checks++;
    if (got !== {1'b1, 8'hFE, 4'b1010}) begin failures++; $display("FAIL sub_borrow got=%0h exp=%0h", got, {1'b1, 8'hFE, 4'b1010}); end
    beat8(3'b000, 8'h7F, 8'h01);
    tick();
    got = {bus8.out_valid, bus8.out, bus8.flag_c, bus8.flag_z, bus8.flag_n, bus8.flag_v};
    checks++;
    if (got !== {1'b1, 8'h80, 4'b0011}) begin failures++; $display("FAIL add_ovf got=%0h exp=%0h", got, {1'b1, 8'h80, 4'b0011}); end
    idle8();
    tick();
    got = {bus8.out_valid, bus8.out, bus8.flag_c, bus8.flag_z, bus8.flag_n, bus8.flag_v};
    checks++;
    if (got !== {1'b0, 8'h80, 4'b0011}) begin failures++; $display("FAIL drain_hold got=%0h exp=%0h", got, {1'b0, 8'h80, 4'b0011}); end
  endtask

  task automatic test_backpressure();
    logic [12:0] got;
    bus8.out_ready = 1'b0;
    beat8(3'b000, 8'h01, 8'h01);
    tick();
    beat8(3'b011, 8'h0F, 8'hF0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (bus8.in_ready !== 1'b0) begin failures++; $display("FAIL stall_ready cyc=%0d got=%0b exp=0", i, bus8.in_ready); end
      tick();
      got = {bus8.out_valid, bus8.out, bus8.flag_c, bus8.flag_z, bus8.flag_n, bus8.flag_v};
      checks++;
      if (got !== {1'b1, 8'h02, 4'b0000}) begin failures++; $display("FAIL stall_hold cyc=%0d got=%0h exp=%0h", i, got, {1'b1, 8'h02, 4'b0000}); end
    end
    bus8.out_ready = 1'b1;
    #1;
    checks++;
    if (bus8.in_ready !== 1'b1) begin failures++; $display("FAIL release_ready got=%0b exp=1", bus8.in_ready); end
    tick();
    got = {bus8.out_valid, bus8.out, bus8.flag_c, bus8.flag_z, bus8.flag_n, bus8.flag_v};
    checks++;
    if (got !== {1'b1, 8'hFF, 4'b0010}) begin failures++; $display("FAIL release_out got=%0h exp=%0h", got, {1'b1, 8'hFF, 4'b0010}); end
    idle8();
    tick();
    checks++;
    if (bus8.out_valid !== 1'b0) begin failures++; $display("FAIL release_drain got=%0b exp=0", bus8.out_valid); end
  endtask

  task automatic test_accumulate();
    logic [7:0] exp_acc [5];
    exp_acc = '{8'h03, 8'h06, 8'h09, 8'h12, 8'h05};
    bus8.out_ready = 1'b1;
    bus8.acc_clr = 1'b1;
    tick();
    bus8.acc_clr = 1'b0;
    checks++;
    if (bus8.acc !== 8'h00) begin failures++; $display("FAIL acc_clear got=%0h exp=0", bus8.acc); end
    bus8.acc_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i < 3) beat8(3'b000, 8'($urandom), 8'h03);
      else if (i == 3) beat8(3'b101, 8'($urandom), 8'h01);
      else begin beat8(3'b000, 8'($urandom), 8'h05); bus8.acc_clr = 1'b1; end
      tick();
      checks++;
      if (bus8.acc !== exp_acc[i] || bus8.out !== exp_acc[i]) begin
        failures++; $display("FAIL acc_step%0d acc=%0h out=%0h exp=%0h", i, bus8.acc, bus8.out, exp_acc[i]);
      end
    end
    idle8();
    bus8.acc_clr = 1'b1;
    tick();
    bus8.acc_clr = 1'b0;
    checks++;
    if (bus8.acc !== 8'h00 || bus8.out !== 8'h05) begin
      failures++; $display("FAIL acc_clr_only acc=%0h out=%0h exp acc=0 out=5", bus8.acc, bus8.out);
    end
  endtask

  task automatic test_reset_stall();
    logic [12:0] got;
    bus8.out_ready = 1'b0;
    beat8(3'b000, 8'h11, 8'hFF);
    bus8.acc_en = 1'b1;
    tick();
    got = {bus8.out_valid, bus8.out, bus8.flag_c, bus8.flag_z, bus8.flag_n, bus8.flag_v};
    checks++;
    if (got !== {1'b1, 8'hFF, 4'b0010} || bus8.acc !== 8'hFF) begin
      failures++; $display("FAIL pre_reset got=%0h acc=%0h exp=%0h acc=ff", got, bus8.acc, {1'b1, 8'hFF, 4'b0010});
    end
    rst = 1'b1;
    beat8(3'b111, 8'h00, 8'h5A);
    tick();
    rst = 1'b0;
    idle8();
    bus8.out_ready = 1'b0;
    #1;
    got = {bus8.out_valid, bus8.out, bus8.flag_c, bus8.flag_z, bus8.flag_n, bus8.flag_v};
    checks++;
    if (got !== 13'h0 || bus8.acc !== 8'h00 || bus8.in_ready !== 1'b1) begin
      failures++; $display("FAIL stall_reset got=%0h acc=%0h rdy=%0b exp=0 acc=0 rdy=1", got, bus8.acc, bus8.in_ready);
    end
  endtask

  task automatic test_random_w8();
    logic            m_valid;
    longint unsigned m_acc, eff;
    mres_t           m_res, m;
    logic            iv, ordy, ae, ac, rdy;
    logic [2:0]      s;
    logic [7:0]      a, b;
    logic [12:0]     got, exp;
    rst = 1'b1;
    idle8();
    tick();
    rst = 1'b0;
    m_valid = 1'b0; m_acc = 0; m_res = '0;
    for (int i = 0; i < 300; i++) begin
      iv = ($urandom_range(3) != 0); ordy = ($urandom_range(3) != 0);
      ae = ($urandom_range(2) == 0); ac = ($urandom_range(7) == 0);
      s = 3'($urandom); a = 8'($urandom); b = 8'($urandom);
      bus8.in_valid = iv; bus8.out_ready = ordy; bus8.acc_en = ae; bus8.acc_clr = ac;
      bus8.sel = s; bus8.a = a; bus8.b = b;
      #1;
      rdy = !m_valid || ordy;
      checks++;
      if (bus8.in_ready !== rdy) begin failures++; $display("FAIL rnd_ready i=%0d got=%0b exp=%0b", i, bus8.in_ready, rdy); end
      eff = ac ? 0 : (ae ? m_acc : longint'(a));
      if (iv && rdy) begin
        m = ref_op(8, int'(s), eff, longint'(b));
        m_res = m;
        m_valid = 1'b1;
        if (ae) m_acc = longint'(m.r);
        else if (ac) m_acc = 0;
      end else begin
        if (ordy) m_valid = 1'b0;
        if (ac) m_acc = 0;
      end
      tick();
      got = {bus8.out_valid, bus8.out, bus8.flag_c, bus8.flag_z, bus8.flag_n, bus8.flag_v};
      exp = {m_valid, m_res.r[7:0], m_res.c, m_res.z, m_res.n, m_res.v};
      checks++;
      if (got !== exp) begin failures++; $display("FAIL rnd_out i=%0d got=%0h exp=%0h", i, got, exp); end
      checks++;
      if (bus8.acc !== 8'(m_acc)) begin failures++; $display("FAIL rnd_acc i=%0d got=%0h exp=%0h", i, bus8.acc, 8'(m_acc)); end
    end
    idle8();
    bus8.out_ready = 1'b1;
    tick();
  endtask

  task automatic test_sweep_w4();
    mres_t      m;
    logic [3:0] a, b;
    logic [8:0] got, exp;
    bus4.out_ready = 1'b1;
    for (int op = 0; op < 8; op++) begin
      for (int k = 0; k < 8; k++) begin
        a = 4'($urandom); b = 4'($urandom);
        bus4.in_valid = 1'b1; bus4.sel = 3'(op); bus4.a = a; bus4.b = b;
        m = ref_op(4, op, longint'(a), longint'(b));
        tick();
        got = {bus4.out_valid, bus4.out, bus4.flag_c, bus4.flag_z, bus4.flag_n, bus4.flag_v};
        exp = {1'b1, m.r[3:0], m.c, m.z, m.n, m.v};
        checks++;
        if (got !== exp) begin failures++; $display("FAIL w4_op%0d a=%0h b=%0h got=%0h exp=%0h", op, a, b, got, exp); end
      end
    end
    bus4.sel = 3'b101; bus4.a = 4'h3; bus4.b = 4'h5;
    tick();
    checks++;
    if (bus4.out !== 4'h6) begin failures++; $display("FAIL w4_shamt_wrap got=%0h exp=6", bus4.out); end
    bus4.in_valid = 1'b0;
    tick();
  endtask

  task automatic test_sweep_w16();
    mres_t       m;
    logic [15:0] a, b;
    logic [20:0] got, exp;
    bus16.out_ready = 1'b1;
    for (int op = 0; op < 8; op++) begin
      for (int k = 0; k < 8; k++) begin
        a = 16'($urandom); b = 16'($urandom);
        if (k == 0) begin a = 16'h7FFF; b = 16'h8001; end
        bus16.in_valid = 1'b1; bus16.sel = 3'(op); bus16.a = a; bus16.b = b;
        m = ref_op(16, op, longint'(a), longint'(b));
        tick();
        got = {bus16.out_valid, bus16.out, bus16.flag_c, bus16.flag_z, bus16.flag_n, bus16.flag_v};
        exp = {1'b1, m.r[15:0], m.c, m.z, m.n, m.v};
        checks++;
        if (got !== exp) begin failures++; $display("FAIL w16_op%0d a=%0h b=%0h got=%0h exp=%0h", op, a, b, got, exp); end
      end
    end
    bus16.in_valid = 1'b0;
    tick();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_flags();
    test_backpressure();
    test_accumulate();
    test_reset_stall();
    test_random_w8();
    test_sweep_w4();
    test_sweep_w16();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered successor to the team's 4-bit combinational ALU, generalised to WIDTH bits with eight operations. Adds carry/zero/negative/overflow flags, an internal accumulator mode, and valid/ready handshakes on both sides. Sits between an operand source (switch/UART front end) and a display or result consumer, with one output register stage.

## Interface
- WIDTH, 8: operand/result width, must be ≥ 2 and a power of two
- clk  input  1  system clock, rising edge
- rst  input  1  reset, synchronous, active-high
- in_valid  input  1  operand/op beat present
- in_ready  output  1  block can accept a beat this cycle
- a  input  WIDTH  operand A (ignored when acc_en=1)
- b  input  WIDTH  operand B
- sel  input  3  operation code
- acc_en  input  1  use accumulator as A and write result back to accumulator
- acc_clr  input  1  clear accumulator (sampled every cycle, no handshake)
- out_valid  output  1  result register holds an unconsumed result
- out_ready  input  1  consumer takes result this cycle
- out  output  WIDTH  registered result
- flag_c, flag_z, flag_n, flag_v  output  1 each  carry/borrow, zero, negative (out MSB), signed overflow
- acc  output  WIDTH  current accumulator value

## Operation
- Opcodes: 000 ADD a+b; 001 OR; 010 AND; 011 XOR (codes 00–11 match the previous ALU's sel); 100 SUB a−b; 101 SHL a by b[log2(WIDTH)−1:0]; 110 SHR logical, same amount; 111 PASS b.
- Width rule: all results truncated to WIDTH bits; no sign extension.
- flag_c: ADD = carry-out; SUB = borrow (1 iff a<b unsigned); all others 0.
- flag_v: ADD/SUB = two's-complement signed overflow; all others 0.
- flag_z = (result == 0); flag_n = result[WIDTH−1]; valid for every opcode.
- Effective A = acc when acc_en=1, else a. If acc_clr=1 in the same cycle, effective A = 0.
- Accumulator update (priority high→low): rst → 0; accepted beat with acc_en=1 → result; acc_clr=1 → 0; else hold.
- acc_clr with no accepted beat clears acc the next edge; out/flags unaffected.

## Timing
- Accept: in_valid && in_ready. in_ready = !out_valid || out_ready (combinational, no dependence on in_valid).
- Latency 1: result and flags registered on the accepting edge, out_valid=1 the following cycle.
- Throughput 1 beat/cycle while out_ready=1.
- Hold: while out_valid && !out_ready, out, flags and out_valid stay constant; no beat accepted; acc unchanged by ops.
- Drain: out_ready && out_valid with no new accept → out_valid=0 next cycle; out/flags keep the last value.
- Simultaneous drain and accept: out_valid stays 1, new result replaces old the same edge.
- Reset (any cycle, including mid-stall): next edge out_valid=0, out=0, all flags 0, acc=0. in_ready reads 1 after reset. A beat presented in the reset cycle is dropped.
- No FSM beyond the out_valid bit; the design has two registered states, EMPTY (out_valid=0) and FULL (out_valid=1).

## Structure
- alu_seq_pkg: opcode localparams/enum (OP_ADD…OP_PASS), SHAMT_W = $clog2(WIDTH) helper.
- Sub-module alu_seq_core: purely combinational datapath (effective A, b, sel → result, c, v). Parametrised on WIDTH. Top holds handshake, output register and accumulator.

## Test plan
- WIDTH=8, ADD a=F0 b=20, out_ready=1 → next cycle out=10, c=1, z=0, n=0, v=0, out_valid=1.
- SUB a=05 b=07 → out=FE, c=1, n=1, v=0. ADD 7F+01 → out=80, v=1, n=1, c=0.
- Backpressure: accept ADD 01+01, hold out_ready=0 for 3 cycles with next beat on in_valid → in_ready=0, out=02 stable. Raise out_ready → next beat accepted that edge, new out next cycle.
- Accumulate: acc_clr, then acc_en ADD b=03 ×3 → acc 03, 06, 09. SHL acc_en b=01 → acc=12. acc_clr with acc_en ADD b=05 → acc=05.
- Reset while out_valid=1 and out_ready=0 → next cycle out_valid=0, out=00, flags 0, acc=00, in_ready=1.
- Sweep all eight opcodes with WIDTH=4 and WIDTH=16 against a reference model; SHL/SHR amount uses only low log2(WIDTH) bits of b (WIDTH=4, b=5 → shift 1).
